fan_rpm_meter: RTL and testbench
================================

# fan_rpm_meter

Measures fan speed from the open-collector tachometer line and produces the 16-bit RPM value that the UART telemetry transmitter packs into its periodic frame. Sits between the fan connector's tach pin and the `rpm` input of the serial reporting stage. Counts debounced falling edges over a fixed gate window and scales the count to revolutions per minute. Publishes a one-cycle update strobe and a stall flag once per window.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: sys_clk frequency in Hz.
- `GATE_MS`, 1000: gate window length in ms.
  - GATE_CYC = (CLK_FREQ/1000)*GATE_MS.
- `PULSES_PER_REV`, 2: tach pulses per revolution.
- `DEBOUNCE_CYC`, 500: cycles a new level must be stable before acceptance (10 µs at 50 MHz).
- `RPM_FACTOR`, derived as 60000/(GATE_MS*PULSES_PER_REV).
  - 30 at defaults.
  - Configurations where this division is not exact are unsupported.

Ports:
- `sys_clk`, in, 1: system clock.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `tach_in`, in, 1: raw tach line, asynchronous to sys_clk, idle high (pull-up).
- `rpm`, out, 16: latest speed in RPM, unsigned.
- `rpm_valid`, out, 1: one-cycle strobe, high in the cycle `rpm` and `stall` update.
- `stall`, out, 1: high when the last completed window contained zero pulses.

## Operation
- **Synchroniser:** 2-FF chain on `tach_in`, both flops reset to 1.
- **Glitch filter:**
  - Filtered level `flt` resets to 1.
  - While the synchronised level ≠ `flt`, a stability counter increments; it clears whenever the levels agree.
  - When the counter reaches DEBOUNCE_CYC−1 with levels still differing, `flt` takes the new level and the counter clears.
- **Edge detect:** a 1→0 transition of `flt` produces a one-cycle `fall` pulse. Rising edges are not counted.
- **Gate counter:** runs 0..GATE_CYC−1 and wraps. The terminal cycle is `gate_end`.
- **Pulse counter:**
  - 16 bits, increments on `fall` and saturates at 65535.
  - On `gate_end` the count is snapshotted into `cnt_latch` and the counter reloads.
  - A `fall` coinciding with `gate_end` is credited to the new window: the counter reloads to 1.
- **Scale pipeline:**
  - Stage 1 (cycle after `gate_end`): `prod` = `cnt_latch` * RPM_FACTOR, computed at full width (≥24 bits).
  - Stage 2: `rpm` = min(`prod`, 65535).
  - In the same cycle, `stall` = (`cnt_latch` == 0) and `rpm_valid` = 1.
- `rpm` and `stall` hold their values between updates.

## Timing
- Reset values: `rpm`=0, `rpm_valid`=0, `stall`=0. All counters and pipeline registers are 0, and `flt`=1.
- Tach edge to `fall`: 2 sync cycles + DEBOUNCE_CYC cycles + 1 cycle.
- `gate_end` to `rpm_valid`: exactly 2 cycles.
- Update period: GATE_CYC cycles. The first `rpm_valid` occurs at cycle GATE_CYC+1 after reset release.
- Pulses shorter than DEBOUNCE_CYC cycles, high or low, are never counted.
- Reset asserted mid-window: all state clears immediately. The next window starts from 0 on release, and no partial window is reported.
- Saturated count (65535) still scales and clamps: `rpm`=65535.

## Configuration
- `FAN_RPM_AVG_EN` defined:
  - A 4-entry history holds the last four clamped window results, reset to 0.
  - An extra pipeline stage is added: `rpm` = (sum of history)>>2, so `gate_end` to `rpm_valid` is 3 cycles.
  - `stall` still reflects only the latest window.
  - The first three reports ramp up from the zero-filled history.
- `FAN_RPM_AVG_EN` undefined: raw per-window result, 2-cycle latency as above.

## Test plan
Bench overrides: CLK_FREQ=100_000, GATE_MS=1000, PULSES_PER_REV=2 (GATE_CYC=100000, factor 30), DEBOUNCE_CYC=4.
- 40 clean pulses (20 cycles low / 20 cycles high) in one window -> `rpm_valid` at window end +2, `rpm`=1200, `stall`=0.
- 40 clean pulses plus 3-cycle-wide low glitches between them -> `rpm`=1200; the glitches are ignored.
- `tach_in` held high for a full window -> `rpm`=0, `stall`=1. Next window with 10 pulses -> `rpm`=300, `stall`=0.
- Pulse period 40 cycles for a full window (2500 pulses, 75000 RPM) -> `rpm`=65535.
- Filter edge arranged to give `fall` exactly on `gate_end` -> the old window excludes it and the new window reports +1 pulse (e.g. 5 vs 4). Reset pulsed mid-window -> outputs return to 0 and the first `rpm_valid` comes GATE_CYC+1 cycles after release.
- With `FAN_RPM_AVG_EN`: windows of 40, 40, 40, 40 pulses -> `rpm` = 300, 600, 900, 1200, each 3 cycles after `gate_end`.

Source files
------------

// File: rtl/fan_rpm_if.sv
// Fan tach / RPM telemetry bundle.
// master: the meter (samples tach, publishes rpm/rpm_valid/stall).
// slave : the fan side driving tach and the telemetry consumer.
interface fan_rpm_if;
   logic        tach_in;
   logic [15:0] rpm;
   logic        rpm_valid;
   logic        stall;

   modport master (input tach_in, output rpm, output rpm_valid, output stall);
   modport slave  (output tach_in, input rpm, input rpm_valid, input stall);
endinterface

// File: rtl/fan_rpm_meter.sv
// Fan tachometer to RPM converter.
// Debounced falling edges of the tach line are counted over a fixed gate
// window, scaled by RPM_FACTOR and clamped to 16 bits once per window.
// Optional build macro FAN_RPM_AVG_EN: reports the mean of the last four
// window results (one extra cycle of latency); stall still tracks only the
// latest window.
module fan_rpm_meter #(
   parameter int CLK_FREQ       = 50_000_000,
   parameter int GATE_MS        = 1000,
   parameter int PULSES_PER_REV = 2,
   parameter int DEBOUNCE_CYC   = 500
) (
   input  logic      sys_clk,
   input  logic      sys_rst_n,
   fan_rpm_if.master bus
);
   localparam int GATE_CYC   = (CLK_FREQ / 1000) * GATE_MS;
   localparam int RPM_FACTOR = 60000 / (GATE_MS * PULSES_PER_REV);
   localparam int GATE_W     = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
   localparam int DEB_W      = $clog2(DEBOUNCE_CYC + 1);

   logic [1:0]        sync_q;
   logic              tach_s;
   logic              flt;
   logic              flt_d;
   logic [DEB_W-1:0]  deb_cnt;
   logic              fall;
   logic [GATE_W-1:0] gate_cnt;
   logic              gate_end;
   logic [15:0]       pulse_cnt;
   logic [15:0]       cnt_latch;
   logic              lat_v;
   logic [31:0]       prod;
   logic [15:0]       rpm_clamp;
   logic [15:0]       rpm_q;
   logic              rpm_valid_q;
   logic              stall_q;

   assign tach_s = sync_q[1];

   // two-flop synchroniser; idle level of the line is high
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) sync_q <= 2'b11;
      else            sync_q <= {sync_q[0], bus.tach_in};
   end

   // glitch filter: a new level must persist DEBOUNCE_CYC cycles to be taken
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         flt     <= 1'b1;
         deb_cnt <= '0;
      end else if (tach_s == flt) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1)) begin
         flt     <= tach_s;
         deb_cnt <= '0;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   // registered falling-edge pulse of the filtered level
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         flt_d <= 1'b1;
         fall  <= 1'b0;
      end else begin
         flt_d <= flt;
         fall  <= flt_d & ~flt;
      end
   end

   assign gate_end = (gate_cnt == GATE_W'(GATE_CYC - 1));

   // free-running gate window counter
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)    gate_cnt <= '0;
      else if (gate_end) gate_cnt <= '0;
      else               gate_cnt <= gate_cnt + 1'b1;
   end

   // saturating pulse counter; a fall on the terminal cycle opens the next window
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pulse_cnt <= '0;
         cnt_latch <= '0;
         lat_v     <= 1'b0;
      end else begin
         lat_v <= gate_end;
         if (gate_end) begin
            cnt_latch <= pulse_cnt;
            pulse_cnt <= fall ? 16'd1 : 16'd0;
         end else if (fall && pulse_cnt != 16'hFFFF) begin
            pulse_cnt <= pulse_cnt + 16'd1;
         end
      end
   end

   // 16 x factor fits in 32 bits for any factor up to 60000
   assign prod      = 32'(cnt_latch) * 32'(RPM_FACTOR);
   assign rpm_clamp = (prod > 32'h0000_FFFF) ? 16'hFFFF : prod[15:0];

`ifdef FAN_RPM_AVG_EN
   logic [15:0] hist0, hist1, hist2, hist3;
   logic        hist_v;
   logic        stall_s;
   logic [17:0] hist_sum;

   assign hist_sum = 18'(hist0) + 18'(hist1) + 18'(hist2) + 18'(hist3);

   // shift the newest clamped window result into the history
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hist0   <= '0;
         hist1   <= '0;
         hist2   <= '0;
         hist3   <= '0;
         hist_v  <= 1'b0;
         stall_s <= 1'b0;
      end else begin
         hist_v <= lat_v;
         if (lat_v) begin
            hist0   <= rpm_clamp;
            hist1   <= hist0;
            hist2   <= hist1;
            hist3   <= hist2;
            stall_s <= (cnt_latch == 16'd0);
         end
      end
   end

   // publish the four-window mean together with the latest stall flag
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rpm_q       <= '0;
         stall_q     <= 1'b0;
         rpm_valid_q <= 1'b0;
      end else begin
         rpm_valid_q <= hist_v;
         if (hist_v) begin
            rpm_q   <= 16'(hist_sum >> 2);
            stall_q <= stall_s;
         end
      end
   end
`else
   // publish the clamped result of the window just closed
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rpm_q       <= '0;
         stall_q     <= 1'b0;
         rpm_valid_q <= 1'b0;
      end else begin
         rpm_valid_q <= lat_v;
         if (lat_v) begin
            rpm_q   <= rpm_clamp;
            stall_q <= (cnt_latch == 16'd0);
         end
      end
   end
`endif

   assign bus.rpm       = rpm_q;
   assign bus.rpm_valid = rpm_valid_q;
   assign bus.stall     = stall_q;
endmodule

// File: tb/tb_fan_rpm_meter.sv
// Bench for fan_rpm_meter. Gate shortened to 5000 cycles (factor 120) so
// every scenario, including 16-bit clamping, fits in a short run.
module tb_fan_rpm_meter;
   localparam int CLK_FREQ = 10_000;
   localparam int GATE_MS  = 500;
   localparam int PPR      = 1;
   localparam int DEB      = 4;
   localparam int G        = (CLK_FREQ / 1000) * GATE_MS;
   localparam int F        = 60000 / (GATE_MS * PPR);
   localparam int FALL_LAT = 2 + DEB + 1;
`ifdef FAN_RPM_AVG_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   fan_rpm_if bus ();

   fan_rpm_meter #(
      .CLK_FREQ(CLK_FREQ), .GATE_MS(GATE_MS),
      .PULSES_PER_REV(PPR), .DEBOUNCE_CYC(DEB)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc;
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) cyc <= 0;
      else            cyc <= cyc + 1;
   end

   int total = 0;
   int bad   = 0;
   int now   = 0;
   int cnt_win [16];
   int hist [$];
   int exp_rpm   = 0;
   int exp_stall = 0;

   task automatic check(input string tag, input int obs, input int expv);
      total++;
      if (obs != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // reference: window w holds every accepted fall whose pulse lands in
   // cycles [w*G-1, (w+1)*G-1); results appear L cycles after the window
   task automatic monitor();
      int k, n, clamp, sum;
      bit v;
      v = (cyc >= G + L) && ((cyc - L) % G == 0);
      check("rpm_valid", int'(bus.rpm_valid), int'(v));
      if (v) begin
         k = (cyc - L) / G;
         n = (k - 1 < 16) ? cnt_win[k-1] : 0;
         clamp = (n * F > 65535) ? 65535 : n * F;
`ifdef FAN_RPM_AVG_EN
         hist.push_back(clamp);
         if (hist.size() > 4) void'(hist.pop_front());
         sum = 0;
         foreach (hist[i]) sum += hist[i];
         exp_rpm = sum / 4;
`else
         sum = 0;
         exp_rpm = clamp + sum;
`endif
         exp_stall = (n == 0) ? 1 : 0;
      end
      check("rpm", int'(bus.rpm), exp_rpm);
      check("stall", int'(bus.stall), exp_stall);
   endtask

   task automatic step(input logic lvl);
      @(negedge sys_clk);
      now = cyc;
      monitor();
      bus.tach_in = lvl;
   endtask

   task automatic hold(input logic lvl, input int n);
      for (int i = 0; i < n; i++) step(lvl);
   endtask

   task automatic note_fall(input int c);
      int w;
      w = (c + FALL_LAT + 1) / G;
      if (w < 16) cnt_win[w]++;
   endtask

   // clean pulse, optionally with a short low glitch inside the high phase
   task automatic pulse(input int lo, input int hi, input int g, input int h2);
      step(1'b0);
      note_fall(now);
      hold(1'b0, lo - 1);
      hold(1'b1, hi);
      if (g > 0) begin
         hold(1'b0, g);
         hold(1'b1, h2);
      end
   endtask

   // idle high so that the next step falls on cycle c
   task automatic idle_until(input int c);
      int guard;
      guard = 0;
      while (now < c - 1 && guard < 100000) begin
         step(1'b1);
         guard++;
      end
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst_n   = 1'b0;
      bus.tach_in = 1'b1;
      #1;
      check("rst_rpm", int'(bus.rpm), 0);
      check("rst_stall", int'(bus.stall), 0);
      check("rst_valid", int'(bus.rpm_valid), 0);
      repeat (3) @(negedge sys_clk);
      check("rst_hold_rpm", int'(bus.rpm), 0);
      check("rst_hold_valid", int'(bus.rpm_valid), 0);
      foreach (cnt_win[i]) cnt_win[i] = 0;
      hist.delete();
      exp_rpm   = 0;
      exp_stall = 0;
      now       = 0;
      sys_rst_n = 1'b1;
   endtask

   initial begin
      int n, lo, hi, g, h1, h2;
      bus.tach_in = 1'b1;
      foreach (cnt_win[i]) cnt_win[i] = 0;
      do_reset();

      // W0: 40 clean pulses
      idle_until(50);
      for (int i = 0; i < 40; i++) pulse(20, 20, 0, 0);
      // W1: 40 pulses with 3-cycle low glitches and 2-cycle high spikes
      idle_until(G + 50);
      for (int i = 0; i < 40; i++) begin
         step(1'b0);
         note_fall(now);
         hold(1'b0, 7);
         hold(1'b1, 2);
         hold(1'b0, 10);
         hold(1'b1, 8);
         hold(1'b0, 3);
         hold(1'b1, 9);
      end
      // W2 idle (stall), W3: 10 pulses
      idle_until(3 * G + 50);
      for (int i = 0; i < 10; i++) pulse(20, 20, 0, 0);
      // W4: minimum-width pulses, enough to clamp
      idle_until(4 * G + 50);
      for (int i = 0; i < 600; i++) pulse(DEB, DEB, 0, 0);
      // W5: 4 pulses, then one whose fall lands on the terminal cycle
      idle_until(5 * G + 50);
      for (int i = 0; i < 4; i++) pulse(20, 20, 0, 0);
      idle_until(6 * G - FALL_LAT - 1);
      pulse(10, 20, 0, 0);
      // W6: 4 more pulses on top of the carried one
      idle_until(6 * G + 100);
      for (int i = 0; i < 4; i++) pulse(20, 20, 0, 0);
      // W7: partial window interrupted by reset
      idle_until(7 * G + 100);
      for (int i = 0; i < 7; i++) pulse(20, 20, 0, 0);
      idle_until(7 * G + 2000);
      do_reset();

      // randomized windows after reset
      for (int w = 0; w < 3; w++) begin
         idle_until(w * G + int'($urandom_range(20, 1500)));
         n = int'($urandom_range(0, 60));
         for (int i = 0; i < n; i++) begin
            lo = int'($urandom_range(DEB, 12));
            if ($urandom_range(0, 3) == 0) begin
               h1 = int'($urandom_range(DEB + 2, 10));
               g  = int'($urandom_range(1, DEB - 1));
               h2 = int'($urandom_range(DEB + 2, 10));
               pulse(lo, h1, g, h2);
            end else begin
               hi = int'($urandom_range(DEB, 12));
               pulse(lo, hi, 0, 0);
            end
         end
      end
      idle_until(3 * G + L + 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
